// File: rtl/pixel_pkg.sv
// Shared pixel types and RGB565->RGB888 expansion, used by the scanout engine
// and by the display-side model.
package pixel_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SYNC,
    ST_STREAM,
    ST_DRAIN
  } scan_state_e;

  localparam int FIFO_DEPTH = 2;

  // Replicating the top bits into the new LSBs maps full-scale to 0xFF exactly.
  function automatic rgb888_t rgb565_to_888(input rgb565_t p);
    rgb888_t o;
    o.r = {p.r, p.r[4:2]};
    o.g = {p.g, p.g[5:4]};
    o.b = {p.b, p.b[4:2]};
    return o;
  endfunction

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry pixel FIFO between the framebuffer read port and the display stream.
// The head entry is held until the consumer accepts it.
module pixel_skid_fifo
  import pixel_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       wr_valid_i,
  input  rgb888_t    wr_data_i,
  output logic       rd_valid_o,
  input  logic       rd_ready_i,
  output rgb888_t    rd_data_o,
  output logic [1:0] count_o
);

  rgb888_t [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic                     rd_ptr_q, rd_ptr_d;
  logic                     wr_ptr_q, wr_ptr_d;
  logic [1:0]               count_q, count_d;
  logic                     push, pop;

  assign rd_valid_o = (count_q != 2'd0);
  assign rd_data_o  = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign pop        = rd_valid_o & rd_ready_i;
  // The producer never overfills; the guard only keeps state sane if it did.
  assign push       = wr_valid_i & ((count_q != 2'd2) | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/pixel_scanout.sv
// Framebuffer scanout: on each display frame toggle, reads WIDTH*HEIGHT RGB565
// words in raster order and streams them out as RGB888 over valid/ready.
module pixel_scanout
  import pixel_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] fb_base_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [15:0]       mem_rdata_i,
  output logic              pixel_valid_o,
  input  logic              pixel_ready_i,
  output logic [23:0]       pixel_data_o,
  input  logic              frame_idx_i,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  scan_state_e       state_q, state_d;
  logic              frame_idx_q;
  logic              sync_pend_q, sync_pend_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              inflight_q, inflight_d;

  logic              sync_evt, start, req, done;
  logic              fifo_valid, pop;
  logic [1:0]        fifo_count;
  rgb888_t           fifo_data;
  logic [2:0]        occ;

  assign sync_evt = frame_idx_i ^ frame_idx_q;
  assign pop      = fifo_valid & pixel_ready_i;
  // Slots already committed after this cycle's pop: stored plus one read in flight.
  assign occ      = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    req     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (sync_pend_q) begin
          start   = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        req = (occ < 3'd2);
        if (req && (idx_q == LAST_IDX)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((fifo_count == 2'd0) && !inflight_q) begin
          done    = 1'b1;
          state_d = ST_WAIT_SYNC;
        end
      end
      default: state_d = ST_WAIT_SYNC;
    endcase
  end

  always_comb begin
    // A toggle arriving in the same cycle a frame starts is kept for the next one.
    sync_pend_d = (sync_pend_q & ~start) | sync_evt;
    base_d      = start ? fb_base_i : base_q;
    idx_d       = idx_q;
    if (start)    idx_d = '0;
    else if (req) idx_d = idx_q + 1'b1;
    inflight_d  = req;
  end

  always_ff @(posedge clk_i) begin
    frame_idx_q <= frame_idx_i;
    if (!rstn_i) begin
      state_q     <= ST_WAIT_SYNC;
      sync_pend_q <= 1'b0;
      base_q      <= '0;
      idx_q       <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_pend_q <= sync_pend_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      inflight_q  <= inflight_d;
    end
  end

  pixel_skid_fifo u_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wr_valid_i (inflight_q),
    .wr_data_i  (rgb565_to_888(rgb565_t'(mem_rdata_i))),
    .rd_valid_o (fifo_valid),
    .rd_ready_i (pixel_ready_i),
    .rd_data_o  (fifo_data),
    .count_o    (fifo_count)
  );

  assign mem_req_o     = req;
  assign mem_addr_o    = req ? (base_q + ADDR_W'(idx_q)) : '0;
  assign pixel_valid_o = fifo_valid;
  assign pixel_data_o  = fifo_valid ? fifo_data : 24'h0;
  assign frame_done_o  = done;
  assign busy_o        = (state_q == ST_STREAM) || (state_q == ST_DRAIN);

endmodule

// File: tb/tb_pixel_scanout.sv
// Self-checking bench for pixel_scanout on a 4x2 frame with a behavioural
// framebuffer, event recorder and arithmetic colour reference.
module tb_pixel_scanout;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rstn, enable, frame_idx, ready;
  logic [AW-1:0] fb_base;
  logic          mem_req, valid, done, busy;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata;
  logic [23:0]   pdata;

  always #5 clk = ~clk;

  pixel_scanout #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .enable_i      (enable),
    .fb_base_i     (fb_base),
    .mem_req_o     (mem_req),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .pixel_valid_o (valid),
    .pixel_ready_i (ready),
    .pixel_data_o  (pdata),
    .frame_idx_i   (frame_idx),
    .frame_done_o  (done),
    .busy_o        (busy)
  );

  typedef struct { int c; int v; } ev_t;

  logic [15:0]   fb [0:(1<<AW)-1];
  ev_t           reqs[$];
  ev_t           hss[$];
  int            dones[$];
  int            cyc = 0;
  int            n_cmp = 0, n_bad = 0;
  int            stab_viol = 0, occ_viol = 0, rd_cnt = 0, hs_cnt = 0;
  logic          mreq = 1'b0;
  logic [AW-1:0] maddr = '0;
  logic          pv = 1'b0, pr = 1'b0, prst = 1'b0;
  logic [23:0]   pd = '0;

  // Recorder: samples mid-cycle, tags events with the cycle number.
  always @(negedge clk) begin
    cyc++;
    mreq  = mem_req;
    maddr = mem_addr;
    if (mem_req === 1'b1) reqs.push_back('{cyc, int'(mem_addr)});
    if (valid === 1'b1 && ready === 1'b1) hss.push_back('{cyc, int'(pdata)});
    if (done === 1'b1) dones.push_back(cyc);
    if (prst && pv && !pr && (valid !== 1'b1 || pdata !== pd)) stab_viol++;
    if (!rstn) begin
      rd_cnt = 0;
      hs_cnt = 0;
    end else begin
      rd_cnt += int'(mem_req);
      hs_cnt += int'(valid && ready);
      if (rd_cnt - hs_cnt > 2) occ_viol++;
    end
    pv = valid; pr = ready; pd = pdata; prst = rstn;
  end

  // Framebuffer: data for a request seen in cycle T is presented during T+1.
  always @(posedge clk) begin
    #1;
    mem_rdata = mreq ? fb[maddr] : 16'($urandom);
  end

  function automatic int ref_px(input int w);
    int r, g, b;
    r = (w >> 11) & 31;
    g = (w >> 5) & 63;
    b = w & 31;
    return ((r * 8 + r / 4) << 16) | ((g * 4 + g / 16) << 8) | (b * 8 + b / 4);
  endfunction

  function automatic int exp_addr(input int base, input int k);
    return (base + k) % (1 << AW);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    reqs.delete();
    hss.delete();
    dones.delete();
  endtask

  task automatic run_until_done(input int n, input int budget);
    for (int i = 0; i < budget && dones.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; frame_idx = 1'b1; ready = 1'b1; fb_base = '0;
    repeat (3) tick();
    @(negedge clk);
    n_cmp++;
    if ({mem_req, valid, done, busy} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_held: req/valid/done/busy=%b want 0000", {mem_req, valid, done, busy});
    end
    tick();
    rstn = 1'b1;
    clear_ev();
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if ({mem_req, valid, done, busy} !== 4'b0 || mem_addr !== '0 || pdata !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req/valid/done/busy=%b addr=%h data=%h want all 0",
               {mem_req, valid, done, busy}, mem_addr, pdata);
    end
    n_cmp++;
    if (reqs.size() != 0 || hss.size() != 0) begin
      n_bad++;
      $display("FAIL reset_no_frame: reads=%0d pixels=%0d want 0/0", reqs.size(), hss.size());
    end
  endtask

  task automatic test_basic();
    int c0, t;
    fb_base = AW'(32'h100); ready = 1'b1;
    clear_ev();
    tick();
    c0 = cyc + 1;
    frame_idx = ~frame_idx;
    run_until_done(1, 40);
    tick();
    t = c0 + 2;
    n_cmp++;
    if (dones.size() != 1 || dones[0] != t + N + 2) begin
      n_bad++;
      $display("FAIL basic_done: count=%0d cyc=%0d want 1 at %0d",
               dones.size(), (dones.size() > 0) ? dones[0] : -1, t + N + 2);
    end
    n_cmp++;
    if (reqs.size() != N) begin
      n_bad++;
      $display("FAIL basic_nreads: got %0d want %0d", reqs.size(), N);
    end
    for (int k = 0; k < N && k < reqs.size(); k++) begin
      n_cmp++;
      if (reqs[k].c != t + k || reqs[k].v != 'h100 + k) begin
        n_bad++;
        $display("FAIL basic_addr[%0d]: cyc %0d addr %h want cyc %0d addr %h",
                 k, reqs[k].c, reqs[k].v, t + k, 'h100 + k);
      end
    end
    n_cmp++;
    if (hss.size() != N) begin
      n_bad++;
      $display("FAIL basic_npix: got %0d want %0d", hss.size(), N);
    end
    for (int k = 0; k < N && k < hss.size(); k++) begin
      n_cmp++;
      if (hss[k].c != t + 2 + k || hss[k].v != ref_px(int'(fb['h100 + k]))) begin
        n_bad++;
        $display("FAIL basic_pix[%0d]: cyc %0d data %h want cyc %0d data %h",
                 k, hss[k].c, hss[k].v, t + 2 + k, ref_px(int'(fb['h100 + k])));
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_conversion();
    logic [15:0] src [5] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410, 16'hFFFF};
    int          want [5] = '{'hFF0000, 'h00FF00, 'h0000FF, 'h848284, 'hFFFFFF};
    for (int k = 0; k < 5; k++) fb['h200 + k] = src[k];
    fb_base = AW'(32'h200); ready = 1'b1;
    clear_ev();
    tick();
    frame_idx = ~frame_idx;
    run_until_done(1, 40);
    tick();
    n_cmp++;
    if (hss.size() != N) begin
      n_bad++;
      $display("FAIL conv_npix: got %0d want %0d", hss.size(), N);
    end
    for (int k = 0; k < 5 && k < hss.size(); k++) begin
      n_cmp++;
      if (hss[k].v != want[k]) begin
        n_bad++;
        $display("FAIL conv_const[%0d]: in %h got %h want %h", k, src[k], hss[k].v, want[k]);
      end
    end
    for (int k = 5; k < N && k < hss.size(); k++) begin
      n_cmp++;
      if (hss[k].v != ref_px(int'(fb['h200 + k]))) begin
        n_bad++;
        $display("FAIL conv_rand[%0d]: got %h want %h", k, hss[k].v, ref_px(int'(fb['h200 + k])));
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int base;
    base = (1 << AW) - 3;
    fb_base = AW'(base);
    clear_ev();
    tick();
    frame_idx = ~frame_idx;
    for (int i = 0; i < 400 && dones.size() < 2; i++) begin
      tick();
      ready = 1'($urandom_range(0, 1));
      if (i == 6) frame_idx = ~frame_idx;
    end
    ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (dones.size() != 2 || reqs.size() != 2 * N || hss.size() != 2 * N) begin
      n_bad++;
      $display("FAIL bp_counts: frames=%0d reads=%0d pixels=%0d want 2/%0d/%0d",
               dones.size(), reqs.size(), hss.size(), 2 * N, 2 * N);
    end
    for (int k = 0; k < 2 * N && k < reqs.size(); k++) begin
      n_cmp++;
      if (reqs[k].v != exp_addr(base, k % N)) begin
        n_bad++;
        $display("FAIL bp_addr[%0d]: got %h want %h", k, reqs[k].v, exp_addr(base, k % N));
      end
    end
    for (int k = 0; k < 2 * N && k < hss.size(); k++) begin
      n_cmp++;
      if (hss[k].v != ref_px(int'(fb[exp_addr(base, k % N)]))) begin
        n_bad++;
        $display("FAIL bp_pix[%0d]: got %h want %h", k, hss[k].v,
                 ref_px(int'(fb[exp_addr(base, k % N)])));
      end
    end
    n_cmp++;
    if (stab_viol != 0) begin
      n_bad++;
      $display("FAIL bp_stable: %0d stalled cycles changed data/valid, want 0", stab_viol);
    end
    n_cmp++;
    if (occ_viol != 0) begin
      n_bad++;
      $display("FAIL bp_occupancy: %0d cycles above 2 outstanding, want 0", occ_viol);
    end
  endtask

  task automatic test_sync();
    ready = 1'b1; enable = 1'b1; fb_base = AW'(32'h40);
    clear_ev();
    repeat (20) tick();
    n_cmp++;
    if (reqs.size() != 0) begin
      n_bad++;
      $display("FAIL sync_none: reads=%0d want 0", reqs.size());
    end
    // two toggles inside one frame: exactly one extra frame, right after done
    clear_ev();
    frame_idx = ~frame_idx;
    repeat (4) tick();
    frame_idx = ~frame_idx;
    repeat (2) tick();
    frame_idx = ~frame_idx;
    run_until_done(2, 80);
    repeat (20) tick();
    n_cmp++;
    if (dones.size() != 2 || reqs.size() != 2 * N) begin
      n_bad++;
      $display("FAIL sync_collapse: frames=%0d reads=%0d want 2/%0d", dones.size(), reqs.size(), 2 * N);
    end
    if (dones.size() >= 1 && reqs.size() > N) begin
      n_cmp++;
      if (reqs[N].c != dones[0] + 2) begin
        n_bad++;
        $display("FAIL sync_backtoback: next read cyc %0d want %0d", reqs[N].c, dones[0] + 2);
      end
    end
    // disable mid-frame: frame finishes, then idle with the new toggle held
    clear_ev();
    frame_idx = ~frame_idx;
    repeat (4) tick();
    enable = 1'b0;
    frame_idx = ~frame_idx;
    run_until_done(1, 40);
    repeat (20) tick();
    @(negedge clk);
    n_cmp++;
    if (dones.size() != 1 || hss.size() != N || reqs.size() != N || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL sync_disable: frames=%0d pixels=%0d reads=%0d busy=%b want 1/%0d/%0d/0",
               dones.size(), hss.size(), reqs.size(), busy, N, N);
    end
    tick();
    enable = 1'b1;
    run_until_done(2, 60);
    n_cmp++;
    if (dones.size() != 2) begin
      n_bad++;
      $display("FAIL sync_reenable: frames=%0d want 2", dones.size());
    end
    repeat (4) tick();
  endtask

  task automatic test_midreset();
    fb_base = AW'(32'h300); ready = 1'b1;
    clear_ev();
    frame_idx = ~frame_idx;
    for (int i = 0; i < 40 && hss.size() < 3; i++) tick();
    ready = 1'b0;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (valid !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_outputs: valid=%b busy=%b req=%b want 0/0/0", valid, busy, mem_req);
    end
    clear_ev();
    repeat (10) tick();
    n_cmp++;
    if (reqs.size() != 0 || hss.size() != 0) begin
      n_bad++;
      $display("FAIL midreset_quiet: reads=%0d pixels=%0d want 0/0", reqs.size(), hss.size());
    end
    ready = 1'b1;
    frame_idx = ~frame_idx;
    run_until_done(1, 40);
    tick();
    n_cmp++;
    if (dones.size() != 1 || hss.size() != N || reqs.size() != N) begin
      n_bad++;
      $display("FAIL midreset_restart: frames=%0d pixels=%0d reads=%0d want 1/%0d/%0d",
               dones.size(), hss.size(), reqs.size(), N, N);
    end
    for (int k = 0; k < N && k < hss.size() && k < reqs.size(); k++) begin
      n_cmp++;
      if (reqs[k].v != 'h300 + k || hss[k].v != ref_px(int'(fb['h300 + k]))) begin
        n_bad++;
        $display("FAIL midreset_pix[%0d]: addr %h data %h want addr %h data %h", k,
                 reqs[k].v, hss[k].v, 'h300 + k, ref_px(int'(fb['h300 + k])));
      end
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) fb[a] = 16'($urandom);
    test_reset();
    test_basic();
    test_conversion();
    test_backpressure();
    test_sync();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
